ahb_default_slave: RTL and testbench

AHB default slave for the bus matrix: it answers every transfer whose address decodes to no real slave. It sits directly upstream of the master-side response mux and drives that mux's default-slave inputs (HRDATAd, HRESPd, HREADYd). It returns the two-cycle AHB ERROR response for every active transfer and a zero-wait OKAY for IDLE/BUSY. It also keeps a small error log (count, last faulting address and attributes) for debug software.

---
 rtl/ahb_default_slave.sv | 108 ++++++++++
 tb/tb_ahb_default_slave.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ahb_default_slave.sv
// AHB default slave: two-cycle ERROR for unmapped transfers, OKAY for IDLE/BUSY,
// plus a small error log (count, last address/attributes) for debug software.
module ahb_default_slave #(
    parameter int          CNT_W      = 16,
    parameter logic [1:0]  RESP_OKAY  = 2'b00,
    parameter logic [1:0]  RESP_ERROR = 2'b01
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             HSEL,
    input  logic [31:0]      HADDR,
    input  logic [1:0]       HTRANS,
    input  logic             HWRITE,
    input  logic [2:0]       HSIZE,
    input  logic             HREADY,
    output logic [31:0]      HRDATA,
    output logic [1:0]       HRESP,
    output logic             HREADYOUT,
    output logic [CNT_W-1:0] err_count,
    output logic [31:0]      err_addr,
    output logic [3:0]       err_attr,
    output logic             err_valid,
    input  logic             err_clr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ERR1 = 2'd1,
        S_ERR2 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             hreadyout_q, hreadyout_d;
    logic [1:0]       hresp_q, hresp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic [3:0]       attr_q, attr_d;
    logic             valid_q, valid_d;

    logic accept;
    logic log_en;
    logic unused_htrans0;

    assign unused_htrans0 = HTRANS[0];
    assign accept = HSEL & HREADY & HTRANS[1];
    // ERR1 never takes a new transfer, so the log only counts responses issued
    assign log_en = accept & (state_q != S_ERR1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept) state_d = S_ERR1;
            S_ERR1:  state_d = S_ERR2;
            S_ERR2:  state_d = accept ? S_ERR1 : S_IDLE;
            default: state_d = S_IDLE;
        endcase
        hreadyout_d = (state_d != S_ERR1);
        hresp_d     = (state_d == S_IDLE) ? RESP_OKAY : RESP_ERROR;
    end

    always_comb begin
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        attr_d  = attr_q;
        valid_d = valid_q;
        if (log_en) begin
            addr_d  = HADDR;
            attr_d  = {HWRITE, HSIZE};
            valid_d = 1'b1;
            if (err_clr)
                cnt_d = CNT_W'(1);
            else if (cnt_q != {CNT_W{1'b1}})
                cnt_d = cnt_q + CNT_W'(1);
        end else if (err_clr) begin
            cnt_d   = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= S_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= RESP_OKAY;
            cnt_q       <= '0;
            addr_q      <= '0;
            attr_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            attr_q      <= attr_d;
            valid_q     <= valid_d;
        end
    end

    assign HRDATA    = 32'h0;
    assign HRESP     = hresp_q;
    assign HREADYOUT = hreadyout_q;
    assign err_count = cnt_q;
    assign err_addr  = addr_q;
    assign err_attr  = attr_q;
    assign err_valid = valid_q;

endmodule

// File: tb/tb_ahb_default_slave.sv
// Bench for ahb_default_slave: directed AHB traffic against a cycle-level
// response/log model, with a 16-bit and a 2-bit counter instance side by side.
module tb_ahb_default_slave;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic        HREADY;
    logic        err_clr;

    logic [31:0] a_rdata, b_rdata;
    logic [1:0]  a_resp, b_resp;
    logic        a_rdy, b_rdy;
    logic [15:0] a_cnt;
    logic [1:0]  b_cnt;
    logic [31:0] a_addr, b_addr;
    logic [3:0]  a_attr, b_attr;
    logic        a_valid, b_valid;

    int checks = 0;
    int errors = 0;

    // model state: cycles of error response still to show (2 = ERR1, 1 = ERR2)
    int          m_left;
    int          m_cnt16, m_cnt2;
    logic [31:0] m_addr;
    logic [3:0]  m_attr;
    logic        m_valid;

    always #5 HCLK = ~HCLK;

    // the response mux is driven by this slave alone, so HREADY is its expected ready
    assign HREADY = (m_left != 2);

    ahb_default_slave #(.CNT_W(16)) u_a (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY),
        .HRDATA(a_rdata), .HRESP(a_resp), .HREADYOUT(a_rdy),
        .err_count(a_cnt), .err_addr(a_addr), .err_attr(a_attr),
        .err_valid(a_valid), .err_clr(err_clr)
    );

    ahb_default_slave #(.CNT_W(2)) u_b (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY),
        .HRDATA(b_rdata), .HRESP(b_resp), .HREADYOUT(b_rdy),
        .err_count(b_cnt), .err_addr(b_addr), .err_attr(b_attr),
        .err_valid(b_valid), .err_clr(err_clr)
    );

    always @(posedge HCLK or posedge HRESET) begin
        bit acc;
        if (HRESET) begin
            m_left  <= 0;
            m_cnt16 <= 0;
            m_cnt2  <= 0;
            m_addr  <= '0;
            m_attr  <= '0;
            m_valid <= 1'b0;
        end else begin
            acc = HSEL && HREADY && HTRANS[1];
            if (acc) m_left <= 2;
            else if (m_left > 0) m_left <= m_left - 1;
            if (acc) begin
                m_addr  <= HADDR;
                m_attr  <= {HWRITE, HSIZE};
                m_valid <= 1'b1;
                m_cnt16 <= err_clr ? 1 : (m_cnt16 < 65535 ? m_cnt16 + 1 : 65535);
                m_cnt2  <= err_clr ? 1 : (m_cnt2 < 3 ? m_cnt2 + 1 : 3);
            end else if (err_clr) begin
                m_cnt16 <= 0;
                m_cnt2  <= 0;
                m_valid <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    bit run_cmp = 1'b0;

    always @(negedge HCLK) begin
        if (run_cmp) begin
            chk("m_rdy_a", a_rdy, m_left != 2);
            chk("m_resp_a", a_resp, (m_left > 0) ? 2'b01 : 2'b00);
            chk("m_rdy_b", b_rdy, m_left != 2);
            chk("m_resp_b", b_resp, (m_left > 0) ? 2'b01 : 2'b00);
            chk("m_rdata", {a_rdata, b_rdata}, 64'h0);
            chk("m_cnt_a", a_cnt, m_cnt16);
            chk("m_cnt_b", b_cnt, m_cnt2);
            chk("m_addr", a_addr, m_addr);
            chk("m_attr", a_attr, m_attr);
            chk("m_valid", a_valid, m_valid);
            chk("m_log_b", {b_addr, b_attr, b_valid}, {m_addr, m_attr, m_valid});
        end
    end

    task automatic cyc(input logic sel, input logic [1:0] tr, input logic [31:0] ad,
                       input logic wr, input logic [2:0] sz, input logic clr);
        HSEL = sel; HTRANS = tr; HADDR = ad; HWRITE = wr; HSIZE = sz; err_clr = clr;
        @(negedge HCLK);
    endtask

    task automatic idle(input logic clr);
        cyc(1'b1, 2'b00, 32'h0, 1'b0, 3'd0, clr);
    endtask

    task automatic resp(input string name, input logic rdy, input logic [1:0] r);
        chk({name, "_rdy"}, a_rdy, rdy);
        chk({name, "_resp"}, a_resp, r);
    endtask

    initial begin
        HRESET = 1'b1;
        HSEL = 0; HTRANS = 0; HADDR = 0; HWRITE = 0; HSIZE = 0; err_clr = 0;
        repeat (2) @(negedge HCLK);
        resp("reset", 1'b1, 2'b00);
        chk("reset_log", {a_cnt, a_addr, a_attr, a_valid}, 53'h0);
        HRESET = 1'b0;
        run_cmp = 1'b1;

        for (int i = 0; i < 4; i++) begin
            idle(1'b0);
            resp("idle", 1'b1, 2'b00);
        end
        cyc(1'b1, 2'b01, 32'h1000, 1'b0, 3'd2, 1'b0);
        resp("busy", 1'b1, 2'b00);
        chk("idle_cnt", {a_cnt, a_valid}, 17'h0);
        cyc(1'b0, 2'b10, 32'h2000, 1'b0, 3'd2, 1'b0);
        resp("nosel", 1'b1, 2'b00);

        cyc(1'b1, 2'b10, 32'hDEAD_0000, 1'b1, 3'd2, 1'b0);
        resp("wr_err1", 1'b0, 2'b01);
        chk("wr_cnt", a_cnt, 1);
        chk("wr_addr", a_addr, 32'hDEAD_0000);
        chk("wr_attr", a_attr, 4'b1010);
        chk("wr_valid", a_valid, 1);
        idle(1'b0);
        resp("wr_err2", 1'b1, 2'b01);
        idle(1'b0);
        resp("wr_done", 1'b1, 2'b00);

        idle(1'b1);
        chk("clr_cnt", {a_cnt, a_valid}, 17'h0);
        chk("clr_addr", a_addr, 32'hDEAD_0000);

        cyc(1'b1, 2'b10, 32'h0000_0100, 1'b0, 3'd2, 1'b0);
        resp("b2b_0", 1'b0, 2'b01);
        cyc(1'b1, 2'b10, 32'h0000_0200, 1'b0, 3'd1, 1'b0);
        resp("b2b_1", 1'b1, 2'b01);
        cyc(1'b1, 2'b10, 32'h0000_0200, 1'b0, 3'd1, 1'b0);
        resp("b2b_2", 1'b0, 2'b01);
        cyc(1'b1, 2'b10, 32'h0000_0300, 1'b0, 3'd0, 1'b0);
        resp("b2b_3", 1'b1, 2'b01);
        cyc(1'b1, 2'b10, 32'h0000_0300, 1'b0, 3'd0, 1'b0);
        resp("b2b_4", 1'b0, 2'b01);
        idle(1'b0);
        resp("b2b_5", 1'b1, 2'b01);
        idle(1'b0);
        resp("b2b_end", 1'b1, 2'b00);
        chk("b2b_cnt", a_cnt, 3);
        chk("b2b_addr", a_addr, 32'h0000_0300);
        chk("b2b_attr", a_attr, 4'b0000);

        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 2'b11, 32'h0000_0400 + i, 1'b1, 3'd0, 1'b0);
            idle(1'b0);
        end
        chk("pre5_cnt", a_cnt, 5);
        idle(1'b0);
        cyc(1'b1, 2'b10, 32'h0000_0500, 1'b0, 3'd1, 1'b1);
        chk("clracc_cnt", a_cnt, 1);
        chk("clracc_valid", a_valid, 1);
        chk("clracc_addr", a_addr, 32'h0000_0500);
        idle(1'b0);
        idle(1'b0);
        idle(1'b1);
        chk("clr2_cnt", {a_cnt, a_valid}, 17'h0);
        chk("clr2_addr", a_addr, 32'h0000_0500);
        chk("clr2_cntb", b_cnt, 0);

        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 2'b10, 32'h0000_0600 + i, 1'b0, 3'd2, 1'b0);
            chk("sat_b", b_cnt, (i < 3) ? i + 1 : 3);
            chk("sat_a", a_cnt, i + 1);
            idle(1'b0);
        end
        idle(1'b0);

        cyc(1'b1, 2'b10, 32'hBAD0_0000, 1'b1, 3'd1, 1'b0);
        resp("rst_err1", 1'b0, 2'b01);
        HSEL = 1'b1; HTRANS = 2'b00;
        #1 HRESET = 1'b1;
        #1;
        resp("rst_async", 1'b1, 2'b00);
        chk("rst_log", {a_cnt, a_addr, a_attr, a_valid}, 53'h0);
        chk("rst_logb", {b_cnt, b_addr, b_attr, b_valid}, 39'h0);
        @(negedge HCLK);
        HRESET = 1'b0;
        idle(1'b0);
        resp("rst_noerr2", 1'b1, 2'b00);
        idle(1'b0);

        run_cmp = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
